// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: on a requested video-mode change it writes
// the PLL reconfig registers (mode, K, C, start), then holds the video-clock
// domain in reset until the PLL has been locked for LOCK_CYCLES cycles.
// Also re-waits for lock whenever lock is lost while idle.
// Optional feature macro PLL_LOCK_TIMEOUT_EN: bounded lock wait, sticky
// lock_err, and a re-issue of the write sequence on timeout.
module pll_reconfig_seq #(
  parameter logic [31:0] K_NTSC         = 32'h0000_0000,
  parameter logic [31:0] K_PAL          = 32'h0000_0000,
  parameter logic [31:0] C_NTSC         = 32'h0000_0000,
  parameter logic [31:0] C_PAL          = 32'h0000_0000,
  parameter int          LOCK_CYCLES    = 1024,
  parameter int          TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pal,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
`ifdef PLL_LOCK_TIMEOUT_EN
  output logic        core_reset,
  output logic        lock_err
`else
  output logic        core_reset
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_MODE   = 3'd1;
  localparam logic [2:0] WR_K      = 3'd2;
  localparam logic [2:0] WR_C      = 3'd3;
  localparam logic [2:0] WR_START  = 3'd4;
  localparam logic [2:0] WAIT_LOCK = 3'd5;
  localparam logic [2:0] STABLE    = 3'd6;

  localparam int            CW       = $clog2(LOCK_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic          cur_mode_q, cur_mode_d;
  logic          tgt_mode_q, tgt_mode_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          busy_q, busy_d;
  logic          crst_q, crst_d;
  logic          lk_s1_q, lk_s2_q;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          lock_err_q, lock_err_d;
  assign lock_err = lock_err_q;
`endif

  assign busy       = busy_q;
  assign core_reset = crst_q;

  // Bus outputs decode straight from state so reset clears them asynchronously.
  always_comb begin
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    case (state_q)
      WR_MODE:  begin mgmt_write = 1'b1; mgmt_address = 6'd0; mgmt_writedata = 32'd0; end
      WR_K:     begin mgmt_write = 1'b1; mgmt_address = 6'd7;
                      mgmt_writedata = tgt_mode_q ? K_PAL : K_NTSC; end
      WR_C:     begin mgmt_write = 1'b1; mgmt_address = 6'd5;
                      mgmt_writedata = tgt_mode_q ? C_PAL : C_NTSC; end
      WR_START: begin mgmt_write = 1'b1; mgmt_address = 6'd2; mgmt_writedata = 32'd1; end
      default:  ;
    endcase
  end

  // Next-state logic for the sequencer, lock counter and status flags.
  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    tgt_mode_d = tgt_mode_q;
    lock_cnt_d = lock_cnt_q;
    busy_d     = busy_q;
    crst_d     = crst_q;
`ifdef PLL_LOCK_TIMEOUT_EN
    tmo_cnt_d  = '0;
    lock_err_d = lock_err_q;
`endif
    case (state_q)
      IDLE: begin
        // core_reset still set here only straight out of reset: wait for
        // initial lock without touching the bus (PLL powers up in NTSC).
        if (crst_q || !lk_s2_q) begin
          state_d    = WAIT_LOCK;
          busy_d     = 1'b1;
          crst_d     = 1'b1;
          lock_cnt_d = '0;
        end else if (pal != cur_mode_q) begin
          state_d    = WR_MODE;
          tgt_mode_d = pal;
          busy_d     = 1'b1;
          crst_d     = 1'b1;
        end
      end
      WR_MODE:  if (!mgmt_waitrequest) state_d = WR_K;
      WR_K:     if (!mgmt_waitrequest) state_d = WR_C;
      WR_C:     if (!mgmt_waitrequest) state_d = WR_START;
      WR_START: begin
        if (!mgmt_waitrequest) begin
          state_d    = WAIT_LOCK;
          cur_mode_d = tgt_mode_q;
          lock_cnt_d = '0;
        end
      end
      WAIT_LOCK: begin
        if (!lk_s2_q) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_LAST) begin
          state_d = STABLE;
          busy_d  = 1'b0;
          crst_d  = 1'b0;
        end else if (lock_cnt_q != '1) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (state_d == WAIT_LOCK && tmo_cnt_q == TMO_LAST) begin
          lock_err_d = 1'b1;
          tgt_mode_d = cur_mode_q;
          state_d    = WR_MODE;
        end
`endif
      end
      STABLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; the lock input is double-flopped into clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_mode_q <= 1'b0;
      tgt_mode_q <= 1'b0;
      lock_cnt_q <= '0;
      busy_q     <= 1'b1;
      crst_q     <= 1'b1;
      lk_s1_q    <= 1'b0;
      lk_s2_q    <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      lock_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      tgt_mode_q <= tgt_mode_d;
      lock_cnt_q <= lock_cnt_d;
      busy_q     <= busy_d;
      crst_q     <= crst_d;
      lk_s1_q    <= pll_locked;
      lk_s2_q    <= lk_s1_q;
`ifdef PLL_LOCK_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      lock_err_q <= lock_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: reset/initial lock, PAL/NTSC write
// sequences, bus stall, mid-sequence mode change, lock loss, async reset,
// and (with PLL_LOCK_TIMEOUT_EN) the lock timeout.
module tb_pll_reconfig_seq;
  localparam logic [31:0] KN = 32'h1111_0001;
  localparam logic [31:0] KP = 32'h2222_0002;
  localparam logic [31:0] CN = 32'h0000_0303;
  localparam logic [31:0] CP = 32'h0000_0404;
  localparam int L = 8;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst, pal, pll_locked, wreq;
  logic [5:0] mgmt_address;
  logic mgmt_write;
  logic [31:0] mgmt_writedata;
  logic busy, core_reset;
`ifdef PLL_LOCK_TIMEOUT_EN
  logic lock_err;
`endif

  pll_reconfig_seq #(.K_NTSC(KN), .K_PAL(KP), .C_NTSC(CN), .C_PAL(CP),
                     .LOCK_CYCLES(L), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .pal(pal), .pll_locked(pll_locked),
    .mgmt_waitrequest(wreq), .mgmt_address(mgmt_address),
    .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .busy(busy),
`ifdef PLL_LOCK_TIMEOUT_EN
    .core_reset(core_reset), .lock_err(lock_err)
`else
    .core_reset(core_reset)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0, wcnt = 0, kn_hold = 0;
  logic [5:0]  wa[$];
  logic [31:0] wd[$];
  int          wcyc[$];
  logic        wbusy[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus monitor sampled mid-cycle: completed writes, K_NTSC hold cycles,
  // and idle-bus zeroing.
  always @(negedge clk) begin
    cyc++;
    if (mgmt_write) begin
      if (mgmt_address == 6'd7 && mgmt_writedata == KN) kn_hold++;
      if (!wreq) begin
        wa.push_back(mgmt_address);
        wd.push_back(mgmt_writedata);
        wcyc.push_back(cyc);
        wbusy.push_back(busy);
        wcnt++;
      end
    end else begin
      chk("bus_zero", mgmt_writedata | 32'(mgmt_address), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel();
    int n = 0;
    do begin
      tick();
      n++;
    end while (core_reset && n < 300);
    chk("rel_timeout", 32'(core_reset), 32'd0);
  endtask

  task automatic check_seq(input int base, input logic p, input logic consec);
    logic [5:0]  ea[4];
    logic [31:0] ed[4];
    ea[0] = 6'd0; ea[1] = 6'd7; ea[2] = 6'd5; ea[3] = 6'd2;
    ed[0] = 32'd0; ed[1] = p ? KP : KN; ed[2] = p ? CP : CN; ed[3] = 32'd1;
    if (wa.size() < base + 4) begin
      chk("seq_len", 32'(wa.size()), 32'(base + 4));
      return;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq%0d_addr", i), 32'(wa[base+i]), 32'(ea[i]));
      chk($sformatf("seq%0d_data", i), wd[base+i], ed[i]);
      chk($sformatf("seq%0d_busy", i), 32'(wbusy[base+i]), 32'd1);
      if (consec && i > 0)
        chk($sformatf("seq%0d_gap", i), 32'(wcyc[base+i] - wcyc[base+i-1]), 32'd1);
    end
  endtask

  initial begin
    int b, kh, n;
    rst = 1'b1; pal = 1'b0; pll_locked = 1'b0; wreq = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_crst", 32'(core_reset), 32'd1);
    chk("rst_wr",   32'(mgmt_write), 32'd0);
    chk("rst_addr", 32'(mgmt_address), 32'd0);
    chk("rst_data", mgmt_writedata, 32'd0);
`ifdef PLL_LOCK_TIMEOUT_EN
    chk("rst_err",  32'(lock_err), 32'd0);
`endif

    // Initial lock: 2 sync edges + LOCK_CYCLES locked edges to STABLE.
    rst = 1'b0;
    repeat (4) tick();
    chk("init_busy", 32'(busy), 32'd1);
    chk("init_crst", 32'(core_reset), 32'd1);
    pll_locked = 1'b1;
    repeat (L + 1) tick();
    chk("init_pre_rel", 32'(core_reset), 32'd1);
    tick();
    chk("init_rel", 32'(core_reset), 32'd0);
    chk("init_rel_busy", 32'(busy), 32'd0);
    tick();
    chk("init_idle_busy", 32'(busy), 32'd0);
    chk("init_no_wr", 32'(wcnt), 32'd0);

    // NTSC -> PAL, no stall: four back-to-back writes.
    b = wcnt; pal = 1'b1;
    wait_rel(); tick();
    check_seq(b, 1'b1, 1'b1);
    chk("pal_cnt", 32'(wcnt - b), 32'd4);

    // PAL -> NTSC with 3 stall cycles on the K write.
    b = wcnt; kh = kn_hold; pal = 1'b0;
    tick(); tick();
    chk("stall_in_k", 32'(mgmt_address), 32'd7);
    wreq = 1'b1;
    repeat (3) tick();
    wreq = 1'b0;
    wait_rel(); tick();
    check_seq(b, 1'b0, 1'b0);
    chk("stall_cnt", 32'(wcnt - b), 32'd4);
    chk("stall_hold", 32'(kn_hold - kh), 32'd4);

    // Mode flips back during WR_C: PAL finishes, then NTSC sequence follows.
    b = wcnt; pal = 1'b1;
    repeat (3) tick();
    chk("flip_in_c", 32'(mgmt_address), 32'd5);
    pal = 1'b0;
    wait_rel(); tick();
    wait_rel(); tick();
    check_seq(b, 1'b1, 1'b1);
    check_seq(b + 4, 1'b0, 1'b1);
    chk("flip_cnt", 32'(wcnt - b), 32'd8);

    // Lock lost for 2 cycles while idle.
    b = wcnt; pll_locked = 1'b0;
    tick(); tick();
    pll_locked = 1'b1;
    tick();
    chk("loss_crst", 32'(core_reset), 32'd1);
    chk("loss_busy", 32'(busy), 32'd1);
    repeat (L) tick();
    chk("loss_pre_rel", 32'(core_reset), 32'd1);
    tick();
    chk("loss_rel", 32'(core_reset), 32'd0);
    tick();
    chk("loss_no_wr", 32'(wcnt - b), 32'd0);

    // Reset mid-write: mgmt_write drops at once, restart waits for lock first.
    pal = 1'b1;
    tick(); tick();
    chk("mid_wr", 32'(mgmt_write), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_wr", 32'(mgmt_write), 32'd0);
    chk("async_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    b = wcnt;
    wait_rel();
    chk("rst2_no_wr", 32'(wcnt - b), 32'd0);
    tick();
    wait_rel(); tick();
    check_seq(b, 1'b1, 1'b1);

`ifdef PLL_LOCK_TIMEOUT_EN
    // Lock never comes: sticky lock_err and the PAL sequence reissued.
    b = wcnt; pll_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!lock_err && n < T + 20);
    chk("tmo_err", 32'(lock_err), 32'd1);
    n = 0;
    while (wcnt < b + 4 && n < 20) begin tick(); n++; end
    check_seq(b, 1'b1, 1'b1);
    pll_locked = 1'b1;
    wait_rel();
    chk("tmo_sticky", 32'(lock_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 Parameter K_NTSC, default 32'h0000_0000, fractional K word for the NTSC video clock (28.636 MHz family, the power-on PLL setting).
REQ-002 Parameter K_PAL, default 32'h0000_0000, fractional K word for the PAL video clock; set at integration.
REQ-003 Parameter C_NTSC / C_PAL, default 32'h0000_0000, C-counter word written for each mode.
REQ-004 Parameter LOCK_CYCLES, default 1024, consecutive locked cycles required before release.
REQ-005 Parameter TIMEOUT_CYCLES, default 65536, lock wait limit, used only under the configuration macro.
REQ-006 clk  in  1  management/system clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 pal  in  1  requested video mode: 1 = PAL, 0 = NTSC; level, synchronous to clk.
REQ-009 pll_locked  in  1  PLL lock indicator; asynchronous, double-flopped internally.
REQ-010 mgmt_waitrequest  in  1  reconfig bus stall.
REQ-011 mgmt_address  out  6  reconfig register address.
REQ-012 mgmt_write  out  1  write strobe.
REQ-013 mgmt_writedata  out  32  write data.
REQ-014 busy  out  1  high while a reconfig sequence or lock wait is in progress.
REQ-015 core_reset  out  1  reset for the video-clock domain consumers; high until the PLL is stable.
REQ-016 lock_err  out  1  sticky lock-timeout flag; exists only under the configuration macro.

Function
REQ-017 States: IDLE, WR_MODE, WR_K, WR_C, WR_START, WAIT_LOCK, STABLE.
REQ-018 cur_mode register holds the mode currently programmed; the reset value is 0 (NTSC, the PLL power-on setting).
REQ-019 IDLE: if pal != cur_mode, latch tgt_mode = pal, assert busy and core_reset, go to WR_MODE next cycle.
REQ-020 Write sequence, one bus write per state, in order: WR_MODE addr 0 data 0 (waitrequest mode); WR_K addr 7 data K_tgt; WR_C addr 5 data C_tgt; WR_START addr 2 data 1.
REQ-021 Bus handshake: address, data and mgmt_write are held constant while mgmt_waitrequest = 1; the write completes on the edge where mgmt_write = 1 and mgmt_waitrequest = 0; the next state is entered on that edge.
REQ-022 mgmt_write is 0 in IDLE, WAIT_LOCK and STABLE; mgmt_address and mgmt_writedata are 0 whenever mgmt_write = 0.
REQ-023 After WR_START completes, cur_mode <= tgt_mode, lock counter cleared, go to WAIT_LOCK.
REQ-024 WAIT_LOCK: the counter increments on each cycle synced lock = 1 and is cleared on any cycle with synced lock = 0; at LOCK_CYCLES-1 go to STABLE.
REQ-025 STABLE: deassert core_reset and busy in the same cycle, then go to IDLE.
REQ-026 A pal change during a sequence does not abort it; after STABLE, IDLE re-evaluates pal and starts a new sequence if it differs from cur_mode.
REQ-027 In IDLE, synced lock = 0 for one or more cycles asserts core_reset and enters WAIT_LOCK without bus writes (lock-loss recovery).
REQ-028 Lock counter width is clog2(LOCK_CYCLES)+1 bits and saturates; it never wraps.

Reset
REQ-029 While rst = 1: state IDLE, cur_mode 0, counters 0, mgmt_write 0, mgmt_address 0, mgmt_writedata 0, busy 1, core_reset 1, lock_err 0.
REQ-030 After rst is released, the block enters WAIT_LOCK and waits for initial lock (busy 1) before first release; no bus writes are issued for NTSC.
REQ-031 rst asserted mid-write drops mgmt_write immediately (asynchronously) and restarts from REQ-030.

Configuration
REQ-032 Macro PLL_LOCK_TIMEOUT_EN defined: WAIT_LOCK counts total cycles; at TIMEOUT_CYCLES without reaching STABLE, lock_err <= 1 (sticky until rst) and the full write sequence for cur_mode restarts at WR_MODE.
REQ-033 Macro undefined: no timeout counter, lock_err is absent from the port list, and WAIT_LOCK waits indefinitely.

Verification
REQ-034 Reset, pll_locked = 1 from cycle 5 -> core_reset falls LOCK_CYCLES+sync cycles later; no mgmt_write pulses.
REQ-035 pal 0->1, waitrequest 0 -> four writes at addresses 0,7,5,2 with data 0,K_PAL,C_PAL,1 on consecutive cycles; busy 1 throughout.
REQ-036 Same with waitrequest = 1 for 3 cycles on the K write -> addr 7 / K_PAL held 4 cycles; write count remains exactly 4.
REQ-037 pal toggles 1->0 during WR_C -> the PAL sequence completes, STABLE, then an NTSC sequence with K_NTSC follows.
REQ-038 In IDLE, pll_locked drops for 2 cycles -> core_reset 1, no writes, release after LOCK_CYCLES locked cycles.
REQ-039 PLL_LOCK_TIMEOUT_EN defined, pll_locked held 0 -> lock_err = 1 at TIMEOUT_CYCLES and the write sequence reissued.
